// File: rtl/spi_lcd_frame.sv
// Byte source for spi_lcd: emits the controller init sequence once after reset,
// then repeats window header + RGB565 pixel stream (high byte first) per frame.
module spi_lcd_frame #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 320,
  parameter logic [7:0]  MADCTL = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        put,
  output logic        full,
  output logic        lcd_dc,
  output logic [7:0]  lcd_out,
  output logic        lcd_put,
  input  logic        lcd_full,
  output logic        ready,
  output logic        frame
);

  localparam longint unsigned Total = 64'(WIDTH) * 64'(HEIGHT);
  localparam int unsigned CntW = $clog2(Total + 1);
  localparam logic [CntW-1:0] LastPix = CntW'(Total - 1);
  localparam logic [15:0] Xe = 16'(WIDTH - 1);
  localparam logic [15:0] Ye = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {
    StInit,
    StHead,
    StPixWait,
    StPixHi,
    StPixLo
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     pix_q, pix_d;
  logic            ready_q, ready_d;
  logic            frame_q, frame_d;
  logic            emits;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      pix_q   <= 16'h0000;
      ready_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      ready_q <= ready_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    ready_d = ready_q;
    frame_d = 1'b0;
    lcd_dc  = 1'b0;
    lcd_out = 8'h00;
    full    = 1'b1;
    // Every state except PIX_WAIT presents a byte; it moves only when accepted.
    emits   = (state_q != StPixWait);
    lcd_put = emits & ~lcd_full & ~reset;

    unique case (state_q)
      StInit: begin
        case (idx_q)
          4'd0:    begin lcd_dc = 1'b0; lcd_out = 8'h01;  end
          4'd1:    begin lcd_dc = 1'b0; lcd_out = 8'h11;  end
          4'd2:    begin lcd_dc = 1'b0; lcd_out = 8'h3A;  end
          4'd3:    begin lcd_dc = 1'b1; lcd_out = 8'h55;  end
          4'd4:    begin lcd_dc = 1'b0; lcd_out = 8'h36;  end
          4'd5:    begin lcd_dc = 1'b1; lcd_out = MADCTL; end
          default: begin lcd_dc = 1'b0; lcd_out = 8'h29;  end
        endcase
        if (lcd_put) begin
          if (idx_q == 4'd6) begin
            idx_d   = 4'd0;
            ready_d = 1'b1;
            state_d = StHead;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      StHead: begin
        case (idx_q)
          4'd0:    begin lcd_dc = 1'b0; lcd_out = 8'h2A;     end
          4'd3:    begin lcd_dc = 1'b1; lcd_out = Xe[15:8];  end
          4'd4:    begin lcd_dc = 1'b1; lcd_out = Xe[7:0];   end
          4'd5:    begin lcd_dc = 1'b0; lcd_out = 8'h2B;     end
          4'd8:    begin lcd_dc = 1'b1; lcd_out = Ye[15:8];  end
          4'd9:    begin lcd_dc = 1'b1; lcd_out = Ye[7:0];   end
          4'd10:   begin lcd_dc = 1'b0; lcd_out = 8'h2C;     end
          default: begin lcd_dc = 1'b1; lcd_out = 8'h00;     end
        endcase
        if (lcd_put) begin
          if (idx_q == 4'd10) begin
            idx_d   = 4'd0;
            cnt_d   = '0;
            state_d = StPixWait;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      StPixWait: begin
        full = 1'b0;
        if (put) begin
          pix_d   = in;
          state_d = StPixHi;
        end
      end

      StPixHi: begin
        lcd_dc  = 1'b1;
        lcd_out = pix_q[15:8];
        if (lcd_put) state_d = StPixLo;
      end

      StPixLo: begin
        lcd_dc  = 1'b1;
        lcd_out = pix_q[7:0];
        if (lcd_put) begin
          if (cnt_q == LastPix) begin
            frame_d = 1'b1;
            state_d = StHead;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StPixWait;
          end
        end
      end

      default: state_d = StInit;
    endcase
  end

  assign ready = ready_q;
  assign frame = frame_q;

endmodule
